// File: rtl/branch_update_unit.sv
// ============================================================================
// branch_update_unit
//
// Purpose
//   Owns the gshare branch predictor state. It takes the resolved-branch
//   record from the EX->R branch register and trains a pattern history table
//   (PHT) of 2-bit saturating counters and a direct-mapped branch target
//   buffer (BTB). It answers the fetch-side lookup combinationally. When a
//   branch was mispredicted it raises a one-cycle registered flush/redirect
//   towards fetch and the ROB, and it restores the speculative global history
//   register (GHR).
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous reset, active low
//   update_signal_R   resolved-branch record valid this cycle
//   prediction_R      direction predicted at fetch
//   actual_outcome_R  resolved direction (1 = taken)
//   ghr_R             GHR snapshot taken when the branch was fetched
//   tag_R             ROB tag of the resolving branch
//   next_addr_R       resolved taken target
//   b_addr_R          branch instruction address
//   f_valid           fetch lookup valid
//   f_pc              fetch address
//   f_pred_taken      predicted taken (combinational)
//   f_target          predicted next fetch address (combinational)
//   f_ghr             current speculative GHR, travels with the branch
//   flush             registered one-cycle misprediction pulse
//   flush_tag         ROB tag of the mispredicted branch
//   redirect_addr     correct fetch address after a misprediction
//
// Optional build macro
//   BR_UPD_STATS_EN   adds saturating 16-bit counters stat_updates and
//                     stat_mispred as extra output ports.
// ============================================================================
module branch_update_unit #(
    parameter int GHR_W   = 5,
    parameter int ADDR_W  = 8,
    parameter int TAG_W   = 5,
    parameter int BTB_IDX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update_signal_R,
    input  logic              prediction_R,
    input  logic              actual_outcome_R,
    input  logic [GHR_W-1:0]  ghr_R,
    input  logic [TAG_W-1:0]  tag_R,
    input  logic [ADDR_W-1:0] next_addr_R,
    input  logic [ADDR_W-1:0] b_addr_R,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              f_pred_taken,
    output logic [ADDR_W-1:0] f_target,
    output logic [GHR_W-1:0]  f_ghr,
    output logic              flush,
    output logic [TAG_W-1:0]  flush_tag,
    output logic [ADDR_W-1:0] redirect_addr
`ifdef BR_UPD_STATS_EN
    ,
    output logic [15:0]       stat_updates,
    output logic [15:0]       stat_mispred
`endif
);

    localparam int PHT_DEPTH = 2 ** GHR_W;
    localparam int BTB_DEPTH = 2 ** BTB_IDX;
    localparam int BTB_TAG_W = ADDR_W - BTB_IDX;

    // Predictor storage
    logic [1:0]           pht        [PHT_DEPTH];
    logic                 btb_valid  [BTB_DEPTH];
    logic [BTB_TAG_W-1:0] btb_tag    [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_target [BTB_DEPTH];

    logic [GHR_W-1:0]     ghr_spec;

    // Lookup-side decode
    logic [GHR_W-1:0]     pidx;
    logic [BTB_IDX-1:0]   f_btb_idx;
    logic [BTB_TAG_W-1:0] f_btb_tag;
    logic                 f_hit;

    // Update-side decode
    logic [GHR_W-1:0]     uidx;
    logic [BTB_IDX-1:0]   u_btb_idx;
    logic [BTB_TAG_W-1:0] u_btb_tag;
    logic                 mis;

    assign f_ghr = ghr_spec;

    // Fetch lookup. Tables are read as they stand before the clock edge, so
    // an update becomes visible to fetch one cycle after it is written.
    // A BTB miss means fetch simply falls through to the next address.
    always_comb begin
        pidx         = ghr_spec ^ f_pc[GHR_W-1:0];
        f_btb_idx    = f_pc[BTB_IDX-1:0];
        f_btb_tag    = f_pc[ADDR_W-1:BTB_IDX];
        f_hit        = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_btb_tag);
        f_pred_taken = f_hit & pht[pidx][1];
        f_target     = f_hit ? btb_target[f_btb_idx] : f_pc + ADDR_W'(1);
    end

    // Update-side decode. The PHT index is rebuilt from the history the
    // branch carried from fetch, not the current speculative history.
    always_comb begin
        uidx      = ghr_R ^ b_addr_R[GHR_W-1:0];
        u_btb_idx = b_addr_R[BTB_IDX-1:0];
        u_btb_tag = b_addr_R[ADDR_W-1:BTB_IDX];
        mis       = update_signal_R && (prediction_R != actual_outcome_R);
    end

    // PHT training: 2-bit saturating counters, weakly not-taken out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (update_signal_R) begin
            if (actual_outcome_R) begin
                if (pht[uidx] != 2'b11) begin
                    pht[uidx] <= pht[uidx] + 2'b01;
                end
            end else begin
                if (pht[uidx] != 2'b00) begin
                    pht[uidx] <= pht[uidx] - 2'b01;
                end
            end
        end
    end

    // BTB training: only taken branches allocate, and an allocation simply
    // replaces whatever entry shared the index. Not-taken branches leave the
    // BTB alone so a loop-exit does not evict the loop's target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (update_signal_R && actual_outcome_R) begin
            btb_valid[u_btb_idx]  <= 1'b1;
            btb_tag[u_btb_idx]    <= u_btb_tag;
            btb_target[u_btb_idx] <= next_addr_R;
        end
    end

    // Speculative history. A misprediction wins over the fetch-side shift
    // because the fetch in that same cycle is on the wrong path and is about
    // to be flushed; the history is rebuilt from the branch's own snapshot
    // plus its real outcome. Correctly predicted branches were already shifted
    // in at fetch time, so resolution leaves the history alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_spec <= '0;
        end else if (mis) begin
            ghr_spec <= {ghr_R[GHR_W-2:0], actual_outcome_R};
        end else if (f_valid && f_hit) begin
            ghr_spec <= {ghr_spec[GHR_W-2:0], f_pred_taken};
        end
    end

    // Flush / redirect. flush is a pulse that follows the resolving cycle by
    // one edge; tag and redirect address are held until the next misprediction
    // so consumers may sample them late. Not-taken recovery restarts fetch at
    // the instruction after the branch, wrapping at the top of the space.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush         <= 1'b0;
            flush_tag     <= '0;
            redirect_addr <= '0;
        end else begin
            flush <= mis;
            if (mis) begin
                flush_tag     <= tag_R;
                redirect_addr <= actual_outcome_R ? next_addr_R
                                                  : b_addr_R + ADDR_W'(1);
            end
        end
    end

`ifdef BR_UPD_STATS_EN
    // Event counters for performance analysis; they stick at all-ones rather
    // than wrapping so a long run never reports a misleadingly small count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_updates <= '0;
            stat_mispred <= '0;
        end else begin
            if (update_signal_R && (stat_updates != 16'hFFFF)) begin
                stat_updates <= stat_updates + 16'd1;
            end
            if (mis && (stat_mispred != 16'hFFFF)) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// ============================================================================
// tb_branch_update_unit
//
// Directed bench for branch_update_unit. Inputs change on the falling clock
// edge and outputs are compared on the falling edge after the rising edge
// that consumed them. Expected values are hand-computed from the gshare
// behaviour (index = history ^ low address bits, BTB tag = addr[7:3]).
// ============================================================================
module tb_branch_update_unit;

    logic       clk;
    logic       rst;
    logic       update_signal_R;
    logic       prediction_R;
    logic       actual_outcome_R;
    logic [4:0] ghr_R;
    logic [4:0] tag_R;
    logic [7:0] next_addr_R;
    logic [7:0] b_addr_R;
    logic       f_valid;
    logic [7:0] f_pc;
    logic       f_pred_taken;
    logic [7:0] f_target;
    logic [4:0] f_ghr;
    logic       flush;
    logic [4:0] flush_tag;
    logic [7:0] redirect_addr;
`ifdef BR_UPD_STATS_EN
    logic [15:0] stat_updates;
    logic [15:0] stat_mispred;
`endif

    int pass_count  = 0;
    int check_count = 0;

    branch_update_unit dut (
        .clk              (clk),
        .rst              (rst),
        .update_signal_R  (update_signal_R),
        .prediction_R     (prediction_R),
        .actual_outcome_R (actual_outcome_R),
        .ghr_R            (ghr_R),
        .tag_R            (tag_R),
        .next_addr_R      (next_addr_R),
        .b_addr_R         (b_addr_R),
        .f_valid          (f_valid),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .f_target         (f_target),
        .f_ghr            (f_ghr),
        .flush            (flush),
        .flush_tag        (flush_tag),
        .redirect_addr    (redirect_addr)
`ifdef BR_UPD_STATS_EN
        ,
        .stat_updates     (stat_updates),
        .stat_mispred     (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch reports tag, observed, expected.
    task automatic check_output(input string name, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    endtask

    // Present one resolved-branch record for the next rising edge.
    task automatic apply_stimulus(input logic [7:0] b_addr, input logic [4:0] ghr,
                                  input logic pred, input logic actual,
                                  input logic [4:0] tag, input logic [7:0] target);
        update_signal_R  = 1'b1;
        b_addr_R         = b_addr;
        ghr_R            = ghr;
        prediction_R     = pred;
        actual_outcome_R = actual;
        tag_R            = tag;
        next_addr_R      = target;
    endtask

    task automatic clear_update();
        update_signal_R  = 1'b0;
        prediction_R     = 1'b0;
        actual_outcome_R = 1'b0;
        ghr_R            = '0;
        tag_R            = '0;
        next_addr_R      = '0;
        b_addr_R         = '0;
    endtask

    initial begin
        rst     = 1'b0;
        f_valid = 1'b0;
        f_pc    = 8'h00;
        clear_update();
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check_output("reset_flush",     32'(flush),         32'h0);
        check_output("reset_flush_tag", 32'(flush_tag),     32'h0);
        check_output("reset_redirect",  32'(redirect_addr), 32'h0);
        check_output("reset_ghr",       32'(f_ghr),         32'h0);
`ifdef BR_UPD_STATS_EN
        check_output("reset_stat_upd",  32'(stat_updates),  32'h0);
        check_output("reset_stat_mis",  32'(stat_mispred),  32'h0);
`endif
        rst = 1'b1;

        // 1. Cold lookup: BTB miss, fall-through target
        f_pc = 8'h10;
        #1;
        check_output("t1_pred",   32'(f_pred_taken), 32'h0);
        check_output("t1_target", 32'(f_target),     32'h11);
        check_output("t1_ghr",    32'(f_ghr),        32'h0);

        // 2. Two taken mispredicts at 0x10 train pht[16] 01->10->11
        @(negedge clk);
        apply_stimulus(8'h10, 5'h00, 1'b0, 1'b1, 5'd3, 8'h40);
        @(negedge clk);
        check_output("t2a_flush",    32'(flush),         32'h1);
        check_output("t2a_tag",      32'(flush_tag),     32'h3);
        check_output("t2a_redirect", 32'(redirect_addr), 32'h40);
        check_output("t2a_ghr",      32'(f_ghr),         32'h01);
        apply_stimulus(8'h10, 5'h00, 1'b0, 1'b1, 5'd4, 8'h40);
        @(negedge clk);
        check_output("t2b_flush", 32'(flush),     32'h1);
        check_output("t2b_tag",   32'(flush_tag), 32'h4);
        // Not-taken mispredict at 0x03 (pht[3] 01->00) drives ghr_spec back to 0
        apply_stimulus(8'h03, 5'h00, 1'b1, 1'b0, 5'd6, 8'h99);
        @(negedge clk);
        check_output("t2c_flush",    32'(flush),         32'h1);
        check_output("t2c_tag",      32'(flush_tag),     32'h6);
        check_output("t2c_redirect", 32'(redirect_addr), 32'h04);
        check_output("t2c_ghr",      32'(f_ghr),         32'h00);
        clear_update();
        f_pc = 8'h10;
        #1;
        check_output("t2_lookup_pred",   32'(f_pred_taken), 32'h1);
        check_output("t2_lookup_target", 32'(f_target),     32'h40);
        @(negedge clk);
        check_output("t2_flush_drop", 32'(flush), 32'h0);

        // 3. Not-taken mispredict at 0xFF: redirect wraps to 0x00
        apply_stimulus(8'hFF, 5'h0A, 1'b1, 1'b0, 5'd9, 8'h77);
        @(negedge clk);
        check_output("t3_flush",    32'(flush),         32'h1);
        check_output("t3_tag",      32'(flush_tag),     32'h9);
        check_output("t3_redirect", 32'(redirect_addr), 32'h00);
        check_output("t3_ghr",      32'(f_ghr),         32'h14);
        clear_update();
        @(negedge clk);
        check_output("t3_flush_one", 32'(flush),         32'h0);
        check_output("t3_hold",      32'(redirect_addr), 32'h00);

        // 4. Fetch hit (pidx 0x14^0x10=4, weak NT) in the same cycle as a mispredict
        f_valid = 1'b1;
        f_pc    = 8'h10;
        #1;
        check_output("t4_hit_target", 32'(f_target),     32'h40);
        check_output("t4_hit_pred",   32'(f_pred_taken), 32'h0);
        apply_stimulus(8'h20, 5'h03, 1'b0, 1'b1, 5'd11, 8'h55);
        @(negedge clk);
        check_output("t4_ghr_recover", 32'(f_ghr),         32'h07);
        check_output("t4_flush",       32'(flush),         32'h1);
        check_output("t4_tag",         32'(flush_tag),     32'hB);
        check_output("t4_redirect",    32'(redirect_addr), 32'h55);
        clear_update();
        f_valid = 1'b0;
        f_pc    = 8'h10;
        #1;
        check_output("t4_evicted_target", 32'(f_target), 32'h11);
        f_pc = 8'h20;
        #1;
        check_output("t4_new_target", 32'(f_target),     32'h55);
        check_output("t4_new_pred",   32'(f_pred_taken), 32'h0);

        // Correct prediction: no flush, history and redirect untouched
        @(negedge clk);
        apply_stimulus(8'h30, 5'h00, 1'b1, 1'b1, 5'd13, 8'h60);
        @(negedge clk);
        check_output("ok_flush",    32'(flush),         32'h0);
        check_output("ok_ghr",      32'(f_ghr),         32'h07);
        check_output("ok_redirect", 32'(redirect_addr), 32'h55);
        clear_update();
        // Fetch hit at 0x30, pidx 0x07^0x10=0x17 (weak NT): history shifts in 0
        f_valid = 1'b1;
        f_pc    = 8'h30;
        #1;
        check_output("ok_target", 32'(f_target), 32'h60);
        @(negedge clk);
        check_output("fetch_shift_ghr", 32'(f_ghr), 32'h0E);
        f_valid = 1'b0;

        // 5. Reset lands between a mispredict and its flush
        apply_stimulus(8'h40, 5'h01, 1'b0, 1'b1, 5'd15, 8'h22);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_output("t5_flush",    32'(flush),         32'h0);
        check_output("t5_tag",      32'(flush_tag),     32'h0);
        check_output("t5_redirect", 32'(redirect_addr), 32'h0);
        check_output("t5_ghr",      32'(f_ghr),         32'h0);
        rst = 1'b1;
        clear_update();
        f_pc = 8'h30;
        #1;
        check_output("t5_lookup_target", 32'(f_target),     32'h31);
        check_output("t5_lookup_pred",   32'(f_pred_taken), 32'h0);
        @(negedge clk);
        check_output("t5_flush_later", 32'(flush), 32'h0);

        // 6. Three updates, one mispredict
        apply_stimulus(8'h08, 5'h00, 1'b1, 1'b1, 5'd1, 8'h30);
        @(negedge clk);
        check_output("t6a_flush", 32'(flush), 32'h0);
        apply_stimulus(8'h09, 5'h00, 1'b0, 1'b0, 5'd1, 8'h00);
        @(negedge clk);
        check_output("t6b_flush", 32'(flush), 32'h0);
        apply_stimulus(8'h0A, 5'h00, 1'b0, 1'b1, 5'd2, 8'h33);
        @(negedge clk);
        check_output("t6c_flush",    32'(flush),         32'h1);
        check_output("t6c_tag",      32'(flush_tag),     32'h2);
        check_output("t6c_redirect", 32'(redirect_addr), 32'h33);
        clear_update();
        @(negedge clk);
        check_output("t6_flush_end", 32'(flush), 32'h0);
`ifdef BR_UPD_STATS_EN
        check_output("t6_stat_updates", 32'(stat_updates), 32'h3);
        check_output("t6_stat_mispred", 32'(stat_mispred), 32'h1);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
